// File: rtl/load_pkg.sv
// Package for the load unit: funct3 encodings, FSM state type, word size
// constant, and request-classification helpers.
// Optional feature macro: MISALIGNED_LOAD_EN adds the RD2/WAIT2 states used
// for two-word (misaligned) loads.
package load_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_t;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    WAIT1
`ifdef MISALIGNED_LOAD_EN
    ,
    RD2,
    WAIT2
`endif
  } state_t;

  function automatic logic is_legal(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  // A half access is misaligned on an odd offset; a word access on any
  // non-zero offset. Byte accesses are never misaligned.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LH, F3_LHU: return off[0];
      F3_LW:         return (off != 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Bus bundle for the load unit: request channel from execute, read channel
// to data memory, and writeback/status outputs.
//   slave  : the load unit itself (takes requests, drives memory and writeback)
//   master : the environment (pipeline + memory)
interface load_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [2:0]            req_funct3;
  logic [REG_AW-1:0]     req_rd;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wb_valid;
  logic [REG_AW-1:0]     wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  load_err;
  logic                  busy;

  modport slave (
    input  req_valid, req_addr, req_funct3, req_rd, mem_rvalid, mem_rdata,
    output req_ready, mem_re, mem_addr, wb_valid, wb_rd, wb_data, load_err, busy
  );

  modport master (
    output req_valid, req_addr, req_funct3, req_rd, mem_rvalid, mem_rdata,
    input  req_ready, mem_re, mem_addr, wb_valid, wb_rd, wb_data, load_err, busy
  );
endinterface

// File: rtl/load_extract.sv
// Combinational byte/half/word selector with sign/zero extension.
//   words  in : {word1, word0}, little-endian byte lanes
//   off    in : byte offset addr[1:0]
//   funct3 in : load type
//   result out: extended load value
module load_extract
  import load_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] words,
  input  logic [1:0]              off,
  input  logic [2:0]              funct3,
  output logic [DATA_WIDTH-1:0]   result
);
  logic [2*DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0]   src;
  logic                    unused_hi;

  assign shifted   = words >> {off, 3'b000};
  assign src       = shifted[DATA_WIDTH-1:0];
  // Upper half of the shifted pair never reaches the result.
  assign unused_hi = ^shifted[2*DATA_WIDTH-1:DATA_WIDTH];

  always_comb begin
    result = src;
    case (funct3)
      F3_LB:   result = {{(DATA_WIDTH-8){src[7]}}, src[7:0]};
      F3_LBU:  result = {{(DATA_WIDTH-8){1'b0}}, src[7:0]};
      F3_LH:   result = {{(DATA_WIDTH-16){src[15]}}, src[15:0]};
      F3_LHU:  result = {{(DATA_WIDTH-16){1'b0}}, src[15:0]};
      default: result = src;
    endcase
  end
endmodule

// File: rtl/load_unit.sv
// Load unit: accepts load requests, issues word-aligned reads to data memory,
// waits for the response and returns the extended result to writeback.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : load_unit_if.slave (request, memory read and writeback channels)
// Optional feature macro: MISALIGNED_LOAD_EN -- misaligned LH/LHU/LW are served
// with two reads and merged; without it they raise load_err with no access.
module load_unit
  import load_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input logic         clk,
  input logic         rst,
  load_unit_if.slave  bus
);
  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   addr_reg, addr_next;
  logic [2:0]              funct3_reg, funct3_next;
  logic [REG_AW-1:0]       rd_reg, rd_next;
  logic                    wb_valid_reg, wb_valid_next;
  logic [REG_AW-1:0]       wb_rd_reg, wb_rd_next;
  logic [DATA_WIDTH-1:0]   wb_data_reg, wb_data_next;
  logic                    load_err_reg, load_err_next;
`ifdef MISALIGNED_LOAD_EN
  logic [DATA_WIDTH-1:0]   word0_reg, word0_next;
`endif

  logic [DATA_WIDTH-1:0]   word_addr;
  logic [2*DATA_WIDTH-1:0] ext_words;
  logic [DATA_WIDTH-1:0]   ext_result;
  logic                    mem_re;
  logic [DATA_WIDTH-1:0]   mem_addr;

  assign word_addr = {addr_reg[DATA_WIDTH-1:2], 2'b00};

  // Read data is merged straight from the bus on the capturing edge, so the
  // result register loads on the same edge that samples mem_rvalid.
  always_comb begin
    ext_words = {{DATA_WIDTH{1'b0}}, bus.mem_rdata};
`ifdef MISALIGNED_LOAD_EN
    if (state_reg == WAIT2) ext_words = {bus.mem_rdata, word0_reg};
`endif
  end

  load_extract #(.DATA_WIDTH(DATA_WIDTH)) u_extract (
    .words  (ext_words),
    .off    (addr_reg[1:0]),
    .funct3 (funct3_reg),
    .result (ext_result)
  );

  always_comb begin
    mem_re   = 1'b0;
    mem_addr = '0;
    case (state_reg)
      RD1: begin
        mem_re   = 1'b1;
        mem_addr = word_addr;
      end
`ifdef MISALIGNED_LOAD_EN
      RD2: begin
        mem_re   = 1'b1;
        mem_addr = word_addr + DATA_WIDTH'(WORD_BYTES);  // wraps at 2^32
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    funct3_next   = funct3_reg;
    rd_next       = rd_reg;
    wb_valid_next = 1'b0;
    wb_rd_next    = wb_rd_reg;
    wb_data_next  = wb_data_reg;
    load_err_next = 1'b0;
`ifdef MISALIGNED_LOAD_EN
    word0_next    = word0_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          addr_next   = bus.req_addr;
          funct3_next = bus.req_funct3;
          rd_next     = bus.req_rd;
`ifdef MISALIGNED_LOAD_EN
          if (!is_legal(bus.req_funct3)) load_err_next = 1'b1;
`else
          if (!is_legal(bus.req_funct3) ||
              is_misaligned(bus.req_funct3, bus.req_addr[1:0])) load_err_next = 1'b1;
`endif
          else state_next = RD1;
        end
      end
      RD1: state_next = WAIT1;
      WAIT1: begin
        if (bus.mem_rvalid) begin
`ifdef MISALIGNED_LOAD_EN
          word0_next = bus.mem_rdata;
          if (is_misaligned(funct3_reg, addr_reg[1:0])) begin
            state_next = RD2;
          end else
`endif
          begin
            state_next    = IDLE;
            wb_valid_next = 1'b1;
            wb_rd_next    = rd_reg;
            wb_data_next  = ext_result;
          end
        end
      end
`ifdef MISALIGNED_LOAD_EN
      RD2: state_next = WAIT2;
      WAIT2: begin
        if (bus.mem_rvalid) begin
          state_next    = IDLE;
          wb_valid_next = 1'b1;
          wb_rd_next    = rd_reg;
          wb_data_next  = ext_result;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      funct3_reg   <= '0;
      rd_reg       <= '0;
      wb_valid_reg <= 1'b0;
      wb_rd_reg    <= '0;
      wb_data_reg  <= '0;
      load_err_reg <= 1'b0;
`ifdef MISALIGNED_LOAD_EN
      word0_reg    <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      funct3_reg   <= funct3_next;
      rd_reg       <= rd_next;
      wb_valid_reg <= wb_valid_next;
      wb_rd_reg    <= wb_rd_next;
      wb_data_reg  <= wb_data_next;
      load_err_reg <= load_err_next;
`ifdef MISALIGNED_LOAD_EN
      word0_reg    <= word0_next;
`endif
    end
  end

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.mem_re    = mem_re;
  assign bus.mem_addr  = mem_addr;
  assign bus.wb_valid  = wb_valid_reg;
  assign bus.wb_rd     = wb_rd_reg;
  assign bus.wb_data   = wb_data_reg;
  assign bus.load_err  = load_err_reg;
endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: byte/half/word extraction, alignment errors,
// address wrap, reset abort with stale response, and back-to-back loads.
module tb_load_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fails  = 0;
  int   re_cnt   = 0;
  int   wb_cnt   = 0;
  int   err_cnt  = 0;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  load_unit_if bus ();

  load_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Pulse counters sample the value held during the cycle just ending.
  always @(posedge clk) begin
    re_cnt  <= re_cnt + int'(bus.mem_re);
    wb_cnt  <= wb_cnt + int'(bus.wb_valid);
    err_cnt <= err_cnt + int'(bus.load_err);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.wb_valid || bus.load_err)
      check("wb_err_exclusive", 32'(bus.wb_valid & bus.load_err), 32'd0);
  end

  // Called at a negedge; presents one request for one cycle.
  task automatic send(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd);
    check("req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    bus.req_rd     = rd;
    @(negedge clk);
    bus.req_valid  = 1'b0;
  endtask

  // Waits (bounded) for a read strobe, checks its address, and answers
  // dly cycles later with a one-cycle mem_rvalid.
  task automatic serve(input logic [31:0] exp_addr, input logic [31:0] data, input int dly);
    int t;
    t = 0;
    while (!bus.mem_re && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("mem_re", 32'(bus.mem_re), 32'd1);
    check("mem_addr", bus.mem_addr, exp_addr);
    repeat (dly) @(negedge clk);
    check("mem_re_one_shot", 32'(bus.mem_re), 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = data;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic check_wb(input logic [4:0] rd, input logic [31:0] data);
    check("wb_valid", 32'(bus.wb_valid), 32'd1);
    check("wb_rd", 32'(bus.wb_rd), 32'(rd));
    check("wb_data", bus.wb_data, data);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] w0, input logic [31:0] w1, input int dly,
                         input bit err, input int nw, input logic [31:0] exp);
    int re0, wb0, er0;
    logic [31:0] base;
    re0  = re_cnt;
    wb0  = wb_cnt;
    er0  = err_cnt;
    base = {addr[31:2], 2'b00};
    @(negedge clk);
    send(addr, f3, rd);
    if (err) begin
      check("load_err", 32'(bus.load_err), 32'd1);
      check("err_mem_re", 32'(bus.mem_re), 32'd0);
      repeat (2) @(negedge clk);
      check("err_re_count", 32'(re_cnt - re0), 32'd0);
      check("err_wb_count", 32'(wb_cnt - wb0), 32'd0);
      check("err_pulse_count", 32'(err_cnt - er0), 32'd1);
      $display("load addr=%08h f3=%0d rd=%0d -> load_err", addr, f3, rd);
    end else begin
      for (int k = 0; k < nw; k++) serve(base + 32'(4 * k), (k == 0) ? w0 : w1, dly);
      check_wb(rd, exp);
      check("busy_done", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("wb_one_shot", 32'(bus.wb_valid), 32'd0);
      check("re_count", 32'(re_cnt - re0), 32'(nw));
      check("no_err", 32'(err_cnt - er0), 32'd0);
      $display("load addr=%08h f3=%0d rd=%0d -> wb_data=%08h (reads=%0d)", addr, f3, rd, exp, nw);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_funct3 = '0;
    bus.req_rd     = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_mem_re", 32'(bus.mem_re), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_load_err", 32'(bus.load_err), 32'd0);
    rst = 1'b0;

    // Byte loads
    do_load(32'h0000_1003, LB,  5'd1, 32'h8012_3456, 32'h0, 1, 1'b0, 1, 32'hFFFF_FF80);
    do_load(32'h0000_1003, LBU, 5'd2, 32'h8012_3456, 32'h0, 2, 1'b0, 1, 32'h0000_0080);
    do_load(32'h0000_1001, LB,  5'd3, 32'h8012_3456, 32'h0, 1, 1'b0, 1, 32'h0000_0034);
    // Half and word loads
    do_load(32'h0000_2002, LH,  5'd4, 32'h8001_7FFF, 32'h0, 3, 1'b0, 1, 32'hFFFF_8001);
    do_load(32'h0000_2002, LHU, 5'd5, 32'h8001_7FFF, 32'h0, 1, 1'b0, 1, 32'h0000_8001);
    do_load(32'h0000_2000, LH,  5'd6, 32'h8001_7FFF, 32'h0, 1, 1'b0, 1, 32'h0000_7FFF);
    do_load(32'h0000_2000, LW,  5'd7, 32'h8001_7FFF, 32'h0, 2, 1'b0, 1, 32'h8001_7FFF);
    // Misaligned word and wrap-around
`ifdef MISALIGNED_LOAD_EN
    do_load(32'h0000_3001, LW, 5'd8, 32'h4433_2211, 32'h8877_6655, 2, 1'b0, 2, 32'h5544_3322);
    do_load(32'hFFFF_FFFE, LW, 5'd9, 32'hAABB_CCDD, 32'h1122_3344, 1, 1'b0, 2, 32'h3344_AABB);
`else
    do_load(32'h0000_3001, LW,  5'd8,  32'h0, 32'h0, 1, 1'b1, 0, 32'h0);
    do_load(32'hFFFF_FFFE, LW,  5'd9,  32'h0, 32'h0, 1, 1'b1, 0, 32'h0);
    do_load(32'h0000_2003, LHU, 5'd10, 32'h0, 32'h0, 1, 1'b1, 0, 32'h0);
`endif
    // Illegal funct3
    do_load(32'h0000_4000, 3'b011, 5'd11, 32'h0, 32'h0, 1, 1'b1, 0, 32'h0);
    do_load(32'h0000_4000, 3'b111, 5'd12, 32'h0, 32'h0, 1, 1'b1, 0, 32'h0);

    // Reset while waiting for the response, then a stale mem_rvalid
    wb0 = wb_cnt;
    @(negedge clk);
    send(32'h0000_5000, LW, 5'd13);
    @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_mem_re", 32'(bus.mem_re), 32'd0);
    check("abort_mem_addr", bus.mem_addr, 32'd0);
    check("abort_wb_data", bus.wb_data, 32'd0);
    check("abort_wb_rd", 32'(bus.wb_rd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    @(negedge clk);
    check("stale_no_wb", 32'(wb_cnt - wb0), 32'd0);
    check("stale_busy", 32'(bus.busy), 32'd0);
    check("stale_load_err", 32'(bus.load_err), 32'd0);
    $display("reset abort in WAIT1 with stale response -> no writeback");

    // Back-to-back: second request accepted in the first wb_valid cycle
    @(negedge clk);
    send(32'h0000_6000, LW, 5'd14);
    serve(32'h0000_6000, 32'hCAFE_F00D, 1);
    check_wb(5'd14, 32'hCAFE_F00D);
    send(32'h0000_7004, LW, 5'd15);
    check("b2b_wb_one_shot", 32'(bus.wb_valid), 32'd0);
    serve(32'h0000_7004, 32'h1234_5678, 4);
    check_wb(5'd15, 32'h1234_5678);
    $display("back-to-back LW rd=14 -> cafef00d, rd=15 -> 12345678");
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
